// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helper for alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_DEC  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU operations (ADD..PASS): result, carry/borrow and signed overflow.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] ext;

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        ext        = '0;
        case (op_i)
            OP_ADD: begin
                ext        = {1'b0, a_i} + {1'b0, b_i};
                result_o   = ext[WIDTH-1:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow (A < B).
                ext        = {1'b0, a_i} - {1'b0, b_i};
                result_o   = ext[WIDTH-1:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_INC: begin
                ext        = {1'b0, a_i} + (WIDTH+1)'(1);
                result_o   = ext[WIDTH-1:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i == MAX_POS);
            end
            OP_DEC: begin
                ext        = {1'b0, a_i} - (WIDTH+1)'(1);
                result_o   = ext[WIDTH-1:0];
                carry_o    = ext[WIDTH];
                overflow_o = (a_i == MIN_NEG);
            end
            OP_PASS: result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, iterative shift/rotate and shift-add multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [3:0]           op_q;
    logic [2*WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     res_q;
    logic                 carry_q, ovf_q, ill_q;

    logic [WIDTH-1:0]     comb_res;
    logic                 comb_carry, comb_ovf;
    logic                 accept, legal, single, needs_iter;
    logic [SW-1:0]        count_in;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   work_step;
    logic                 fin_c, last_step;

    alu_seq_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a_i        (A),
        .b_i        (B),
        .op_i       (opcode),
        .result_o   (comb_res),
        .carry_o    (comb_carry),
        .overflow_o (comb_ovf)
    );

    assign accept     = in_valid && (state_q == IDLE);
    assign legal      = (opcode <= OP_MUL);
    assign single     = (opcode <= OP_PASS);
    assign count_in   = B[SW-1:0];
    assign needs_iter = legal && ((is_shift(opcode) && (count_in != '0)) || (opcode == OP_MUL));
    assign last_step  = (cnt_q == CW'(1));

    // One bit step of the iterative datapath; MUL keeps {product_hi, multiplier} in work_q.
    always_comb begin
        lo        = work_q[WIDTH-1:0];
        mul_sum   = '0;
        work_step = work_q;
        fin_c     = 1'b0;
        case (op_q)
            OP_SHL: begin work_step[WIDTH-1:0] = {lo[WIDTH-2:0], 1'b0};       fin_c = lo[WIDTH-1]; end
            OP_SHR: begin work_step[WIDTH-1:0] = {1'b0, lo[WIDTH-1:1]};       fin_c = lo[0];       end
            OP_ASR: begin work_step[WIDTH-1:0] = {lo[WIDTH-1], lo[WIDTH-1:1]}; fin_c = lo[0];      end
            OP_ROL: begin work_step[WIDTH-1:0] = {lo[WIDTH-2:0], lo[WIDTH-1]}; fin_c = lo[WIDTH-1]; end
            OP_ROR: begin work_step[WIDTH-1:0] = {lo[0], lo[WIDTH-1:1]};       fin_c = lo[0];      end
            default: begin
                mul_sum = work_q[0] ? ({1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                                    : {1'b0, work_q[2*WIDTH-1:WIDTH]};
                work_step = {mul_sum, work_q[WIDTH-1:1]};
                fin_c     = |work_step[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = needs_iter ? BUSY : DONE;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            work_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            op_q  <= opcode;
            ovf_q <= 1'b0;
            ill_q <= 1'b0;
            if (!legal) begin
                res_q   <= '0;
                carry_q <= 1'b0;
                ill_q   <= 1'b1;
            end else if (single) begin
                res_q   <= comb_res;
                carry_q <= comb_carry;
                ovf_q   <= comb_ovf;
            end else if (is_shift(opcode)) begin
                work_q <= {{WIDTH{1'b0}}, A};
                cnt_q  <= CW'(count_in);
                if (count_in == '0) begin
                    res_q   <= A;
                    carry_q <= 1'b0;
                end
            end else begin
                work_q  <= {{WIDTH{1'b0}}, B};
                mcand_q <= A;
                cnt_q   <= CW'(WIDTH);
            end
        end else if (state_q == BUSY) begin
            work_q <= work_step;
            cnt_q  <= cnt_q - CW'(1);
            if (last_step) begin
                res_q   <= work_step[WIDTH-1:0];
                carry_q <= fin_c;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        Result    = res_q;
        Zero      = (res_q == '0);
        Negative  = res_q[WIDTH-1];
        Carry     = carry_q;
        Overflow  = ovf_q;
        Illegal   = ill_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=8) with handshake and reset sequences.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] A, B, Result;
    logic [3:0] opcode;
    logic       Zero, Carry, Negative, Overflow, Illegal;

    int tests = 0;
    int fails = 0;

    alu_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Carry     (Carry),
        .Negative  (Negative),
        .Overflow  (Overflow),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a, b, res;
        logic       z, c, n, v, ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] res, input logic z,
                                input logic c, input logic n, input logic v, input logic ill,
                                input int lat);
        vec_t t;
        t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
        t.z = z; t.c = c; t.n = n; t.v = v; t.ill = ill; t.lat = lat;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one request while idle; return cycles from accept edge until out_valid.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        opcode = op; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b, lat);
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " Result"}, Result, v.res);
        check({v.name, " Zero"}, Zero, v.z);
        check({v.name, " Carry"}, Carry, v.c);
        check({v.name, " Negative"}, Negative, v.n);
        check({v.name, " Overflow"}, Overflow, v.v);
        check({v.name, " Illegal"}, Illegal, v.ill);
        retire();
    endtask

    initial begin
        int  lat;
        bit  seen;

        //                name         op     A      B      Res    Z  C  N  V  I  lat
        vecs.push_back(mk("add_ff_01", 4'd0,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("add_7f_01", 4'd0,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk("sub_80_01", 4'd1,  8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("sub_00_01", 4'd1,  8'h00, 8'h01, 8'hFF, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk("and",       4'd2,  8'hA5, 8'h0F, 8'h05, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("or",        4'd3,  8'hA0, 8'h05, 8'hA5, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("xor",       4'd4,  8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("inc_7f",    4'd5,  8'h7F, 8'h00, 8'h80, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk("inc_ff",    4'd5,  8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("dec_80",    4'd6,  8'h80, 8'h00, 8'h7F, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("dec_00",    4'd6,  8'h00, 8'h00, 8'hFF, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk("pass",      4'd7,  8'h5A, 8'h33, 8'h5A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ror_01_1",  4'd12, 8'h01, 8'h01, 8'h80, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk("shl_81_3",  4'd8,  8'h81, 8'h03, 8'h08, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk("asr_80_a",  4'd10, 8'h80, 8'h0A, 8'hE0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk("shr_81_1",  4'd9,  8'h81, 8'h01, 8'h40, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk("rol_80_1",  4'd11, 8'h80, 8'h01, 8'h01, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk("rol_81_4",  4'd11, 8'h81, 8'h04, 8'h18, 0, 0, 0, 0, 0, 5));
        vecs.push_back(mk("shl_cnt0",  4'd8,  8'h81, 8'h08, 8'h81, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("mul_10_10", 4'd13, 8'h10, 8'h10, 8'h00, 1, 1, 0, 0, 0, 9));
        vecs.push_back(mk("mul_0f_0f", 4'd13, 8'h0F, 8'h0F, 8'hE1, 0, 0, 1, 0, 0, 9));
        vecs.push_back(mk("mul_ff_ff", 4'd13, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 0, 0, 9));
        vecs.push_back(mk("illegal_e", 4'd14, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0, 1, 1));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset Result", Result, 0);
        check("reset flags", {Carry, Overflow, Illegal, Negative}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: result held while out_ready is low, intervening request dropped.
        issue(4'd0, 8'h01, 8'h02, lat);
        check("hold latency", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b1; opcode = 4'd0; A = 8'h10; B = 8'h10;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("hold Result", Result, 8'h03);
            check("hold flags", {Zero, Carry, Negative, Overflow, Illegal}, 0);
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
        end
        retire();
        check("release in_ready", in_ready, 1);
        check("release out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("dropped request", out_valid, 0);

        // out_ready and in_valid together in DONE: only the handshake completes.
        issue(4'd0, 8'h04, 8'h04, lat);
        check("overlap first Result", Result, 8'h08);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd0; A = 8'h09; B = 8'h09;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("overlap out_valid", out_valid, 0);
        check("overlap in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("overlap second valid", out_valid, 1);
        check("overlap second Result", Result, 8'h12);
        retire();

        // Reset in the 4th cycle of a multiply aborts it without any result.
        @(negedge clk);
        opcode = 4'd13; A = 8'h10; B = 8'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-mul busy", in_ready, 0);
        rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort Result", Result, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no result", seen, 0);
        check("abort idle", in_ready, 1);
        run_vec(mk("illegal_f", 4'd15, 8'h12, 8'h34, 8'h00, 1, 0, 0, 0, 1, 1));
        run_vec(mk("add_02_03", 4'd0,  8'h02, 8'h03, 8'h05, 0, 0, 0, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
